// File: rtl/urt_tx_req_sched_if.sv
// urt_tx_req_sched_if
//   Bundle of the request/grant signals between the UART command analyser,
//   the TX request scheduler and the UART TX packet generator.
//
//   i_req              analyser -> scheduler  read-request pulses, one bit per item
//   i_down_stream_rdy  generator -> scheduler grant enable
//   i_pkg_done         generator -> scheduler packet fully handed to the TX FIFO
//   o_pkg_start        scheduler -> generator one-cycle packet start pulse
//   o_pkg_sel          scheduler -> generator granted request index
//   o_busy             scheduler status, high while a packet or gap is in progress
//   o_pend             scheduler status, pending request vector
//   o_merge_cnt        scheduler status, saturating count of coalesced requests
//   o_timeout          scheduler status, one-cycle pulse on completion timeout
//
//   master: the side that drives requests/handshake (analyser + generator model)
//   slave : the scheduler itself
interface urt_tx_req_sched_if #(
  parameter int NUM_REQ = 20,
  parameter int IDX_W   = 5
);
  logic [NUM_REQ-1:0] i_req;
  logic               i_down_stream_rdy;
  logic               i_pkg_done;
  logic               o_pkg_start;
  logic [IDX_W-1:0]   o_pkg_sel;
  logic               o_busy;
  logic [NUM_REQ-1:0] o_pend;
  logic [15:0]        o_merge_cnt;
  logic               o_timeout;

  modport master (
    output i_req,
    output i_down_stream_rdy,
    output i_pkg_done,
    input  o_pkg_start,
    input  o_pkg_sel,
    input  o_busy,
    input  o_pend,
    input  o_merge_cnt,
    input  o_timeout
  );

  modport slave (
    input  i_req,
    input  i_down_stream_rdy,
    input  i_pkg_done,
    output o_pkg_start,
    output o_pkg_sel,
    output o_busy,
    output o_pend,
    output o_merge_cnt,
    output o_timeout
  );
endinterface

// File: rtl/urt_tx_req_sched.sv
// urt_tx_req_sched
//   Latches read-request pulses into a pending vector and grants them to the
//   UART TX packet generator round-robin, one packet at a time. After each
//   packet (completed or timed out) an idle gap is inserted before the next
//   grant, so a stalled generator cannot hold the TX path forever.
//
//   clk_100m  system clock
//   rst_100m  synchronous active-low reset
//   bus       urt_tx_req_sched_if.slave (requests, handshake, status outputs)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no packet in flight; grant when something pends and rdy=1
//   START     | one cycle: o_pkg_start high, clear winner's pending bit
//   WAIT_DONE | waiting for i_pkg_done, bounded by the timeout counter
//   GAP       | GAP_CYC idle cycles before the next grant may be issued
module urt_tx_req_sched #(
  parameter int NUM_REQ     = 20,
  parameter int IDX_W       = 5,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic               clk_100m,
  input logic               rst_100m,
  urt_tx_req_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);

  // Where a finished or abandoned packet goes next.
  localparam state_t POST_PKT = (GAP_CYC == 0) ? IDLE : GAP;

  state_t             state;
  logic [NUM_REQ-1:0] pend;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   sel;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [15:0]        merge_cnt;
  logic               pkg_start_q;
  logic               busy_q;
  logic               timeout_q;

  logic [NUM_REQ-1:0] clr_mask;
  logic [NUM_REQ-1:0] pend_nxt;
  logic               merge_hit;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;

  // Pending update: the granted bit is cleared in START, but a new request
  // for the same bit in that cycle re-arms it (set wins, not a merge).
  always_comb begin
    clr_mask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      clr_mask[k] = (state == START) && (sel == IDX_W'(k));
    end
    pend_nxt  = (pend & ~clr_mask) | bus.i_req;
    merge_hit = |(bus.i_req & pend & ~clr_mask);
  end

  // Round-robin search: first pending index strictly after ptr, wrapping.
  always_comb begin
    int cand;
    cand    = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_vld && pend[cand]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk_100m) begin
    if (!rst_100m) begin
      state       <= IDLE;
      pend        <= '0;
      ptr         <= PTR_RST;
      sel         <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      merge_cnt   <= '0;
      pkg_start_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      pend        <= pend_nxt;
      pkg_start_q <= 1'b0;
      timeout_q   <= 1'b0;

      if (merge_hit && (merge_cnt != 16'hFFFF)) begin
        merge_cnt <= merge_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (win_vld && bus.i_down_stream_rdy) begin
            sel         <= win_idx;
            state       <= START;
            pkg_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        START: begin
          ptr     <= sel;
          tmo_cnt <= TMO_LOAD;
          state   <= WAIT_DONE;
        end

        // Down-counter loaded with TIMEOUT_CYC-1; firing at a count of 1
        // makes the registered o_timeout land TIMEOUT_CYC cycles after START.
        WAIT_DONE: begin
          if (bus.i_pkg_done) begin
            state   <= POST_PKT;
            gap_cnt <= GAP_LOAD;
            busy_q  <= (POST_PKT != IDLE);
          end else if (tmo_cnt <= TMO_W'(1)) begin
            timeout_q <= 1'b1;
            state     <= POST_PKT;
            gap_cnt   <= GAP_LOAD;
            busy_q    <= (POST_PKT != IDLE);
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_pkg_start = pkg_start_q;
  assign bus.o_pkg_sel   = sel;
  assign bus.o_busy      = busy_q;
  assign bus.o_pend      = pend;
  assign bus.o_merge_cnt = merge_cnt;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_urt_tx_req_sched.sv
// tb_urt_tx_req_sched
//   Self-checking bench for urt_tx_req_sched. A timestamp-based model of the
//   scheduler (pending set, pointer, packet start / done / free times) predicts
//   every output for every cycle; directed scenarios add hand-computed literal
//   expectations, followed by a long randomized run.
module tb_urt_tx_req_sched;
  localparam int NUM_REQ     = 20;
  localparam int IDX_W       = 5;
  localparam int GAP_CYC     = 16;
  localparam int TIMEOUT_CYC = 50;

  logic clk_100m = 1'b0;
  logic rst_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  urt_tx_req_sched_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

  urt_tx_req_sched #(
    .NUM_REQ(NUM_REQ),
    .IDX_W(IDX_W),
    .GAP_CYC(GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_100m(clk_100m),
    .rst_100m(rst_100m),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // model state
  bit [NUM_REQ-1:0] m_pend;
  int m_ptr, m_sel, m_merge;
  bit m_waiting;
  int m_start_cyc, m_free_cyc;
  bit e_start, e_busy, e_timeout;

  int grants[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_n, act, exp);
    end
  endtask

  // Advance the model across the current cycle given that cycle's inputs.
  task automatic model_step(input bit [NUM_REQ-1:0] req, input bit rdy, input bit done,
                            input bit rst_n);
    int c, w, w_idx;
    bit [NUM_REQ-1:0] old_pend;
    bit hit, clr_k;
    c = cyc_n;
    if (!rst_n) begin
      m_pend = '0; m_ptr = NUM_REQ - 1; m_sel = 0; m_merge = 0;
      m_waiting = 0; m_start_cyc = -1; m_free_cyc = c + 1;
      e_start = 0; e_busy = 0; e_timeout = 0;
      return;
    end
    old_pend = m_pend;
    hit = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      clr_k = (c == m_start_cyc) && (k == m_sel);
      if (req[k] && old_pend[k] && !clr_k) hit = 1;
      if (clr_k) m_pend[k] = 1'b0;
      if (req[k]) m_pend[k] = 1'b1;
    end
    if (hit && m_merge < 65535) m_merge++;
    e_timeout = 0;
    if (c == m_start_cyc) begin
      m_ptr = m_sel;
      m_waiting = 1;
    end else if (m_waiting) begin
      if (done) begin
        m_waiting = 0;
        m_free_cyc = c + 1 + GAP_CYC;
      end else if (c == m_start_cyc + TIMEOUT_CYC - 1) begin
        m_waiting = 0;
        e_timeout = 1;
        m_free_cyc = c + 1 + GAP_CYC;
      end
    end else if (c >= m_free_cyc && old_pend != '0 && rdy) begin
      w = -1;
      for (int i = 1; i <= NUM_REQ; i++) begin
        w_idx = (m_ptr + i) % NUM_REQ;
        if (w < 0 && old_pend[w_idx]) w = w_idx;
      end
      m_sel = w;
      m_start_cyc = c + 1;
    end
    e_start = (m_start_cyc == c + 1);
    e_busy  = e_start || m_waiting || (c + 1 < m_free_cyc);
  endtask

  // Drive one cycle of inputs, step the model, then compare at the negedge.
  task automatic cyc(input bit [NUM_REQ-1:0] req, input bit rdy, input bit done, input bit rst_n);
    bus.i_req = req;
    bus.i_down_stream_rdy = rdy;
    bus.i_pkg_done = done;
    rst_100m = rst_n;
    model_step(req, rdy, done, rst_n);
    @(posedge clk_100m);
    @(negedge clk_100m);
    cyc_n++;
    chk("pkg_start", 32'(bus.o_pkg_start), 32'(e_start));
    chk("pkg_sel",   32'(bus.o_pkg_sel),   32'(m_sel));
    chk("busy",      32'(bus.o_busy),      32'(e_busy));
    chk("pend",      32'(bus.o_pend),      32'(m_pend));
    chk("merge_cnt", 32'(bus.o_merge_cnt), 32'(m_merge));
    chk("timeout",   32'(bus.o_timeout),   32'(e_timeout));
  endtask

  // Run ncyc cycles returning done on the first waiting cycle; log grants.
  task automatic collect(input int ncyc);
    grants.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (bus.o_pkg_start === 1'b1) grants.push_back(int'(bus.o_pkg_sel));
      cyc('0, 1'b1, m_waiting, 1'b1);
    end
  endtask

  function automatic int gq(input int i);
    return (i < grants.size()) ? grants[i] : -1;
  endfunction

  int cnt_a, off_tmo, off_grant, sel_grant;
  bit [NUM_REQ-1:0] r;
  bit r_rdy, r_done, r_rst, slow;

  initial begin
    bus.i_req = '0;
    bus.i_down_stream_rdy = 1'b0;
    bus.i_pkg_done = 1'b0;

    // reset
    cyc('0, 1'b1, 1'b0, 1'b0);
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_pend", 32'(bus.o_pend), 32'd0);
    chk("rst_merge", 32'(bus.o_merge_cnt), 32'd0);
    chk("rst_sel", 32'(bus.o_pkg_sel), 32'd0);
    cyc('0, 1'b1, 1'b0, 1'b1);

    // single request: start at t+2, done 5 cycles later, 16 gap cycles
    cyc(20'h00004, 1'b1, 1'b0, 1'b1);
    cyc('0, 1'b1, 1'b0, 1'b1);
    chk("t1_start", 32'(bus.o_pkg_start), 32'd1);
    chk("t1_sel", 32'(bus.o_pkg_sel), 32'd2);
    repeat (5) cyc('0, 1'b1, 1'b0, 1'b1);
    cyc('0, 1'b1, 1'b1, 1'b1);
    repeat (15) cyc('0, 1'b1, 1'b0, 1'b1);
    chk("t1_busy_gap_end", 32'(bus.o_busy), 32'd1);
    cyc('0, 1'b1, 1'b0, 1'b1);
    chk("t1_busy_low", 32'(bus.o_busy), 32'd0);

    // simultaneous requests from reset pointer: 0, 4, 19
    cyc('0, 1'b1, 1'b0, 1'b0);
    cyc('0, 1'b1, 1'b0, 1'b1);
    cyc(20'h80011, 1'b1, 1'b0, 1'b1);
    collect(80);
    chk("t2_ngrants", 32'(grants.size()), 32'd3);
    chk("t2_g0", 32'(gq(0)), 32'd0);
    chk("t2_g1", 32'(gq(1)), 32'd4);
    chk("t2_g2", 32'(gq(2)), 32'd19);
    chk("t2_pend", 32'(bus.o_pend), 32'd0);
    chk("t2_merge", 32'(bus.o_merge_cnt), 32'd0);

    // wrap: grant 3, re-request 1 and 3 in the START cycle of 3
    cyc(20'h00008, 1'b1, 1'b0, 1'b1);
    cyc('0, 1'b1, 1'b0, 1'b1);
    chk("t3_sel3", 32'(bus.o_pkg_sel), 32'd3);
    cyc(20'h0000A, 1'b1, 1'b0, 1'b1);
    chk("t3_setwins_pend", 32'(bus.o_pend), 32'h0000A);
    chk("t3_setwins_merge", 32'(bus.o_merge_cnt), 32'd0);
    collect(60);
    chk("t3_ngrants", 32'(grants.size()), 32'd2);
    chk("t3_g0", 32'(gq(0)), 32'd1);
    chk("t3_g1", 32'(gq(1)), 32'd3);

    // coalescing: three pulses on bit 5 while held off
    cyc(20'h00020, 1'b0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc(20'h00020, 1'b0, 1'b0, 1'b1);
    cyc(20'h00020, 1'b0, 1'b0, 1'b1);
    chk("t4_merge", 32'(bus.o_merge_cnt), 32'd2);
    chk("t4_pend", 32'(bus.o_pend), 32'h00020);
    collect(60);
    chk("t4_ngrants", 32'(grants.size()), 32'd1);
    chk("t4_g0", 32'(gq(0)), 32'd5);

    // backpressure on bit 7 for 100 cycles
    cyc(20'h00080, 1'b0, 1'b0, 1'b1);
    cnt_a = 0;
    for (int i = 0; i < 100; i++) begin
      cyc('0, 1'b0, 1'b0, 1'b1);
      if (bus.o_pkg_start === 1'b1) cnt_a++;
    end
    chk("t5_no_start", 32'(cnt_a), 32'd0);
    cyc('0, 1'b1, 1'b0, 1'b1);
    chk("t5_start", 32'(bus.o_pkg_start), 32'd1);
    chk("t5_sel", 32'(bus.o_pkg_sel), 32'd7);

    // timeout on packet 7; bit 9 queued behind it
    cyc(20'h00200, 1'b1, 1'b0, 1'b1);
    cnt_a = 0; off_tmo = -1; off_grant = -1; sel_grant = -1;
    for (int off = 1; off <= 80; off++) begin
      if (bus.o_timeout === 1'b1) begin cnt_a++; off_tmo = off; end
      if (bus.o_pkg_start === 1'b1 && off_grant < 0) begin
        off_grant = off; sel_grant = int'(bus.o_pkg_sel);
      end
      cyc('0, 1'b1, 1'b0, 1'b1);
    end
    chk("t6_tmo_count", 32'(cnt_a), 32'd1);
    chk("t6_tmo_offset", 32'(off_tmo), 32'd50);
    chk("t6_next_offset", 32'(off_grant), 32'd67);
    chk("t6_next_sel", 32'(sel_grant), 32'd9);

    // reset during WAIT_DONE with 0x300 still pending
    cyc('0, 1'b1, 1'b0, 1'b0);
    cyc('0, 1'b1, 1'b0, 1'b1);
    cyc(20'h00001, 1'b1, 1'b0, 1'b1);
    cyc(20'h00300, 1'b1, 1'b0, 1'b1);
    cyc('0, 1'b1, 1'b0, 1'b1);
    chk("t7_pend_before", 32'(bus.o_pend), 32'h00300);
    chk("t7_busy_before", 32'(bus.o_busy), 32'd1);
    cyc('0, 1'b1, 1'b0, 1'b0);
    chk("t7_pend", 32'(bus.o_pend), 32'd0);
    chk("t7_busy", 32'(bus.o_busy), 32'd0);
    chk("t7_start", 32'(bus.o_pkg_start), 32'd0);
    chk("t7_timeout", 32'(bus.o_timeout), 32'd0);
    cyc('0, 1'b1, 1'b1, 1'b1);
    chk("t7_late_done_busy", 32'(bus.o_busy), 32'd0);
    repeat (10) cyc('0, 1'b1, 1'b0, 1'b1);

    // randomized traffic
    slow = 0;
    for (int n = 0; n < 6000; n++) begin
      if (n % 500 == 0) slow = ($urandom_range(0, 2) == 0);
      r = '0;
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
      if ($urandom_range(0, 15) == 0) r = r | NUM_REQ'($urandom);
      r_rdy  = ($urandom_range(0, 9) != 0);
      r_done = slow ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 5) == 0);
      r_rst  = ($urandom_range(0, 999) != 0);
      cyc(r, r_rdy, r_done, r_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
